// File: rtl/counter_b4_sequencer_if.sv
// Command bus into the 4-bit counter sequencer.
// The host drives the command fields; the sequencer returns cmd_ready.
interface counter_b4_sequencer_if #(
  parameter int LEN_W = 8
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_mode;
  logic [3:0]       cmd_d;
  logic [LEN_W-1:0] cmd_len;

  modport master (
    output cmd_valid, cmd_mode, cmd_d, cmd_len,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_mode, cmd_d, cmd_len,
    output cmd_ready
  );
endinterface

// File: rtl/counter_b4_sequencer.sv
// Queues {mode, D, len} commands and drives the 4-bit counter:
// preload D, check the load ack, then run len cycles counting rco.
module counter_b4_sequencer #(
  parameter int DEPTH = 4,
  parameter int LEN_W = 8,
  parameter int RCO_W = 4
) (
  input  logic                   b4_clk,
  input  logic                   b4_reset,
  counter_b4_sequencer_if.slave  cmd,
  input  logic                   abort,
  output logic                   b4_enable,
  output logic [1:0]             b4_mode,
  output logic [3:0]             b4_D,
  input  logic                   b4_rco,
  input  logic                   b4_load,
  output logic                   busy,
  output logic                   done,
  output logic [RCO_W-1:0]       rco_cnt,
  output logic                   err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam int EW = 2 + 4 + LEN_W;

  typedef enum logic [2:0] {
    IDLE, LOAD, CHECK, RUN, DONE
  } state_t;

  state_t state, state_n;

  logic [EW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic             full, empty, push, pop;
  logic [EW-1:0]    head;
  logic [1:0]       w_mode;
  logic [LEN_W-1:0] run_left;

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];
  assign push  = cmd.cmd_valid && cmd.cmd_ready;

  assign cmd.cmd_ready = !full && !abort && !b4_reset;
  assign busy = (state != IDLE) || !empty;

  // FIFO storage; no reset needed, pointers qualify contents
  always_ff @(posedge b4_clk) begin
    if (push)
      mem[wr_ptr] <= {cmd.cmd_mode, cmd.cmd_d, cmd.cmd_len};
  end

  // FIFO pointers and occupancy; abort flushes
  always_ff @(posedge b4_clk or posedge b4_reset) begin
    if (b4_reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (abort) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // state register
  always_ff @(posedge b4_clk or posedge b4_reset) begin
    if (b4_reset) state <= IDLE;
    else          state <= state_n;
  end

  // next state and FIFO pop
  always_comb begin
    state_n = state;
    pop     = 1'b0;
    if (abort) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = LOAD;
          end
        end
        LOAD: state_n = CHECK;
        CHECK: begin
          if (run_left == '0 || w_mode == 2'b11)
            state_n = DONE;
          else
            state_n = RUN;
        end
        RUN: begin
          if (run_left <= LEN_W'(1))
            state_n = DONE;
        end
        DONE: begin
          if (!empty) begin
            pop     = 1'b1;
            state_n = LOAD;
          end else begin
            state_n = IDLE;
          end
        end
        default: state_n = IDLE;
      endcase
    end
  end

  // registered counter controls, working regs and status
  always_ff @(posedge b4_clk or posedge b4_reset) begin
    if (b4_reset) begin
      b4_enable <= 1'b0;
      b4_mode   <= 2'b00;
      b4_D      <= 4'h0;
      done      <= 1'b0;
      rco_cnt   <= '0;
      err       <= 1'b0;
      w_mode    <= 2'b00;
      run_left  <= '0;
    end else begin
      b4_enable <= (state_n == LOAD) || (state_n == RUN);
      done      <= (state_n == DONE);
      if (pop) begin
        w_mode   <= head[EW-1 -: 2];
        b4_D     <= head[LEN_W +: 4];
        run_left <= head[LEN_W-1:0];
        b4_mode  <= 2'b11;
        rco_cnt  <= '0;
      end
      if (state == CHECK && !abort) begin
        if (!b4_load) err <= 1'b1;
        if (state_n == RUN) b4_mode <= w_mode;
      end
      if (state == RUN && !abort) begin
        run_left <= run_left - 1'b1;
        if (b4_rco && rco_cnt != '1)
          rco_cnt <= rco_cnt + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_counter_b4_sequencer.sv
// Directed bench for counter_b4_sequencer with a behavioural
// 4-bit counter model answering load acks and rco.
module tb_counter_b4_sequencer;
  logic       clk = 1'b0;
  logic       rst;
  logic       abort;
  logic       b4_enable;
  logic [1:0] b4_mode;
  logic [3:0] b4_D;
  logic       b4_rco;
  logic       b4_load;
  logic       busy;
  logic       done;
  logic [3:0] rco_cnt;
  logic       err;

  logic [3:0] q;
  logic       ack;
  logic       ack_kill;

  int ntests = 0;
  int nfail  = 0;

  bit         mon_en = 0;
  int         dcount = 0;
  int         lad = 0;
  bit         prev_done = 0;
  logic [3:0] dvals [$];

  counter_b4_sequencer_if #(.LEN_W(8)) bus ();

  counter_b4_sequencer #(
    .DEPTH(4), .LEN_W(8), .RCO_W(4)
  ) dut (
    .b4_clk   (clk),
    .b4_reset (rst),
    .cmd      (bus),
    .abort    (abort),
    .b4_enable(b4_enable),
    .b4_mode  (b4_mode),
    .b4_D     (b4_D),
    .b4_rco   (b4_rco),
    .b4_load  (b4_load),
    .busy     (busy),
    .done     (done),
    .rco_cnt  (rco_cnt),
    .err      (err)
  );

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q   <= 4'h0;
      ack <= 1'b0;
    end else begin
      ack <= b4_enable && (b4_mode == 2'b11);
      if (b4_enable) begin
        case (b4_mode)
          2'b00: q <= q + 4'd3;
          2'b01: q <= q - 4'd1;
          2'b10: q <= q + 4'd1;
          2'b11: q <= b4_D;
        endcase
      end
    end
  end

  assign b4_rco  = (b4_mode == 2'b01) ? (q == 4'h0) : (q == 4'hF);
  assign b4_load = ack && !ack_kill;

  always @(negedge clk) begin
    if (mon_en) begin
      if (prev_done && b4_enable && b4_mode == 2'b11) lad++;
      if (b4_enable && b4_mode == 2'b11) dvals.push_back(b4_D);
      if (done) dcount++;
      prev_done = done;
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [1:0] m,
                      input logic [3:0] d,
                      input logic [7:0] l);
    int n;
    n = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_mode  = m;
    bus.cmd_d     = d;
    bus.cmd_len   = l;
    #1;
    while (!bus.cmd_ready && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("push_accept", {31'd0, bus.cmd_ready}, 1);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n;
    n = 0;
    while (!done && n < 200) begin
      @(negedge clk);
      n++;
    end
    check(tag, {31'd0, done}, 1);
  endtask

  initial begin
    int runcnt;
    int dn;
    logic [3:0] rco_at;
    logic [3:0] q_at;

    rst = 1'b1;
    abort = 1'b0;
    ack_kill = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_mode = 2'b00;
    bus.cmd_d = 4'h0;
    bus.cmd_len = 8'd0;
    repeat (2) @(negedge clk);
    check("rst_enable", {31'd0, b4_enable}, 0);
    check("rst_mode", {30'd0, b4_mode}, 0);
    check("rst_D", {28'd0, b4_D}, 0);
    check("rst_done", {31'd0, done}, 0);
    check("rst_rco", {28'd0, rco_cnt}, 0);
    check("rst_err", {31'd0, err}, 0);
    check("rst_busy", {31'd0, busy}, 0);
    check("rst_ready", {31'd0, bus.cmd_ready}, 0);
    rst = 1'b0;
    @(negedge clk);
    check("ready_after_rst", {31'd0, bus.cmd_ready}, 1);

    // load-only command
    push(2'b11, 4'hA, 8'd0);
    check("lo_idle_busy", {31'd0, busy}, 1);
    check("lo_idle_en", {31'd0, b4_enable}, 0);
    @(negedge clk);
    check("lo_load_en", {31'd0, b4_enable}, 1);
    check("lo_load_mode", {30'd0, b4_mode}, 3);
    check("lo_load_D", {28'd0, b4_D}, 4'hA);
    @(negedge clk);
    check("lo_check_en", {31'd0, b4_enable}, 0);
    check("lo_check_done", {31'd0, done}, 0);
    @(negedge clk);
    check("lo_done", {31'd0, done}, 1);
    check("lo_err", {31'd0, err}, 0);
    @(negedge clk);
    check("lo_done_end", {31'd0, done}, 0);
    check("lo_busy_end", {31'd0, busy}, 0);

    // 20-cycle up+1 run from 0: one rco at Q=15
    push(2'b10, 4'h0, 8'd20);
    runcnt = 0;
    dn = 0;
    rco_at = 4'h0;
    q_at = 4'h0;
    repeat (40) begin
      @(negedge clk);
      if (b4_enable && b4_mode == 2'b10) runcnt++;
      if (done) begin
        dn++;
        rco_at = rco_cnt;
        q_at = q;
      end
    end
    check("run_cycles", runcnt, 20);
    check("run_dones", dn, 1);
    check("run_rco", {28'd0, rco_at}, 1);
    check("run_q_end", {28'd0, q_at}, 4);
    check("run_rco_hold", {28'd0, rco_cnt}, 1);
    check("run_err", {31'd0, err}, 0);

    // missing load ack sets sticky err
    ack_kill = 1'b1;
    push(2'b11, 4'h5, 8'd0);
    wait_done("ack_done");
    check("ack_err", {31'd0, err}, 1);
    @(negedge clk);
    ack_kill = 1'b0;
    push(2'b10, 4'h1, 8'd3);
    wait_done("ack_good_done");
    check("ack_err_sticky", {31'd0, err}, 1);
    check("ack_good_rco", {28'd0, rco_cnt}, 0);
    repeat (2) @(negedge clk);

    // abort during RUN with two queued
    push(2'b10, 4'h0, 8'd50);
    push(2'b10, 4'h0, 8'd5);
    push(2'b10, 4'h0, 8'd5);
    repeat (2) @(negedge clk);
    check("ab_in_run", {29'd0, b4_enable, b4_mode}, 3'b110);
    check("ab_queued", {31'd0, busy}, 1);
    abort = 1'b1;
    #1;
    check("ab_ready", {31'd0, bus.cmd_ready}, 0);
    @(negedge clk);
    abort = 1'b0;
    check("ab_busy", {31'd0, busy}, 0);
    check("ab_en", {31'd0, b4_enable}, 0);
    check("ab_done", {31'd0, done}, 0);
    check("ab_err_kept", {31'd0, err}, 1);
    dn = 0;
    repeat (6) begin
      @(negedge clk);
      if (done || busy) dn++;
    end
    check("ab_stays_idle", dn, 0);

    // back-to-back: fill FIFO behind a long command
    mon_en = 1;
    push(2'b10, 4'h0, 8'd30);
    for (int i = 1; i <= 4; i++)
      push(2'b10, 4'(i), 8'd2);
    bus.cmd_valid = 1'b1;
    bus.cmd_mode = 2'b10;
    bus.cmd_d = 4'h5;
    bus.cmd_len = 8'd2;
    #1;
    check("b2b_full_stall", {31'd0, bus.cmd_ready}, 0);
    check("b2b_dones_early", dcount, 0);
    push(2'b10, 4'h5, 8'd2);
    dn = 0;
    while (dcount < 6 && dn < 300) begin
      @(negedge clk);
      dn++;
    end
    repeat (4) @(negedge clk);
    mon_en = 0;
    check("b2b_dones", dcount, 6);
    check("b2b_no_gap", lad, 5);
    check("b2b_loads", dvals.size(), 6);
    if (dvals.size() == 6) begin
      for (int i = 0; i < 6; i++)
        check("b2b_order", {28'd0, dvals[i]}, i);
    end
    check("b2b_idle_end", {31'd0, busy}, 0);

    // async reset mid-RUN
    push(2'b10, 4'h0, 8'd40);
    push(2'b10, 4'h0, 8'd4);
    repeat (4) @(negedge clk);
    check("rr_in_run", {31'd0, b4_enable}, 1);
    #2;
    rst = 1'b1;
    #1;
    check("rr_en", {31'd0, b4_enable}, 0);
    check("rr_busy", {31'd0, busy}, 0);
    check("rr_err", {31'd0, err}, 0);
    check("rr_ready", {31'd0, bus.cmd_ready}, 0);
    check("rr_rco", {28'd0, rco_cnt}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rr_queue_lost", {31'd0, busy}, 0);
    check("rr_ready_back", {31'd0, bus.cmd_ready}, 1);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
